// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter stage: FSM states and redirect priorities.
package pc_unit_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [1:0] PRI_BR   = 2'd0;
   localparam logic [1:0] PRI_JMP  = 2'd1;
   localparam logic [1:0] PRI_ERET = 2'd2;
   localparam logic [1:0] PRI_EXC  = 3'd3;

   // Equal priority counts as a win so the most recent redirect of a class replaces an older one.
   function automatic logic priWins(input logic [1:0] newPri, input logic [1:0] heldPri);
      return newPri >= heldPri;
   endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational priority mux over the redirect sources: exc > eret > jmp > br.
module pc_redirect_sel
   import pc_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VEC = 32'h0000_0001
)
(
   input  logic        exc_i,
   input  logic        eret_i,
   input  logic [31:0] epc_i,
   input  logic        jmp_i,
   input  logic [31:0] jmpTarget_i,
   input  logic        brTaken_i,
   input  logic [31:0] brTarget_i,
   output logic        hit_o,
   output logic [1:0]  pri_o,
   output logic [31:0] target_o
);

   always_comb begin
      hit_o    = 1'b0;
      pri_o    = PRI_BR;
      target_o = 32'h0000_0000;
      if (exc_i) begin
         hit_o    = 1'b1;
         pri_o    = PRI_EXC;
         target_o = EXC_VEC;
      end else if (eret_i) begin
         hit_o    = 1'b1;
         pri_o    = PRI_ERET;
         target_o = epc_i;
      end else if (jmp_i) begin
         hit_o    = 1'b1;
         pri_o    = PRI_JMP;
         target_o = jmpTarget_i;
      end else if (brTaken_i) begin
         hit_o    = 1'b1;
         pri_o    = PRI_BR;
         target_o = brTarget_i;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register stage: selects the next fetch PC and holds redirects
// that arrive while fetch cannot advance until the next advance.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_0001
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        fetch_ready,
   input  logic [31:0] npc_in,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        eret,
   input  logic [31:0] epc_in,
   input  logic        exc,
   output logic [31:0] pc_out,
   output logic        fetch_valid,
   output logic        redir_pend
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pendPc_q, pendPc_d;
   logic [1:0]  pendPri_q, pendPri_d;

   logic        redirHit;
   logic [1:0]  redirPri;
   logic [31:0] redirTarget;
   logic        advance;
   logic        newWins;

   pc_redirect_sel #(
      .EXC_VEC(EXC_VEC)
   ) uRedirSel (
      .exc_i       (exc),
      .eret_i      (eret),
      .epc_i       (epc_in),
      .jmp_i       (jmp),
      .jmpTarget_i (jmp_target),
      .brTaken_i   (br_taken),
      .brTarget_i  (br_target),
      .hit_o       (redirHit),
      .pri_o       (redirPri),
      .target_o    (redirTarget)
   );

   assign fetch_valid = (state_q != ST_BOOT);
   assign redir_pend  = (state_q == ST_HOLD);
   assign pc_out      = pc_q;
   assign advance     = fetch_valid & fetch_ready & ~stall;
   assign newWins     = redirHit & priWins(redirPri, pendPri_q);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pendPc_d  = pendPc_q;
      pendPri_d = pendPri_q;
      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (advance) begin
               pc_d = redirHit ? redirTarget : npc_in;
            end else if (redirHit) begin
               pendPc_d  = redirTarget;
               pendPri_d = redirPri;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // A held redirect always replaces the sequential path; npc_in is stale here.
            if (advance) begin
               pc_d      = newWins ? redirTarget : pendPc_q;
               pendPc_d  = 32'h0000_0000;
               pendPri_d = PRI_BR;
               state_d   = ST_RUN;
            end else if (newWins) begin
               pendPc_d  = redirTarget;
               pendPri_d = redirPri;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_BOOT;
         pc_q      <= RESET_PC;
         pendPc_q  <= 32'h0000_0000;
         pendPri_q <= PRI_BR;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pendPc_q  <= pendPc_d;
         pendPri_q <= pendPri_d;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: each scenario queues steps, and the expected
// PC/valid/pending state of every step is scoreboarded and compared after the edge.
module tb_pc_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_0001;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        fetch_ready;
   logic [31:0] npc_in;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        eret;
   logic [31:0] epc_in;
   logic        exc;
   logic [31:0] pc_out;
   logic        fetch_valid;
   logic        redir_pend;

   typedef struct {
      logic        rstN;
      logic        stall;
      logic        rdy;
      logic        exc;
      logic        eret;
      logic        jmp;
      logic        br;
      logic [31:0] epc;
      logic [31:0] jt;
      logic [31:0] bt;
      logic [31:0] expPc;
      logic        expFv;
      logic        expRp;
   } step_t;

   step_t       plan[$];
   step_t       sb[$];
   logic [31:0] modelPc;
   int          checks;
   int          errors;

   pc_unit #(
      .RESET_PC(RESET_PC),
      .EXC_VEC (EXC_VEC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .fetch_ready(fetch_ready),
      .npc_in     (npc_in),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .eret       (eret),
      .epc_in     (epc_in),
      .exc        (exc),
      .pc_out     (pc_out),
      .fetch_valid(fetch_valid),
      .redir_pend (redir_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic planStep(input logic rstN, input logic stl, input logic rdy,
                           input logic ex, input logic er, input logic jp, input logic br,
                           input logic [31:0] epc, input logic [31:0] jt, input logic [31:0] bt,
                           input logic [31:0] expPc, input logic expFv, input logic expRp);
      step_t s;
      s.rstN = rstN; s.stall = stl; s.rdy = rdy;
      s.exc = ex; s.eret = er; s.jmp = jp; s.br = br;
      s.epc = epc; s.jt = jt; s.bt = bt;
      s.expPc = expPc; s.expFv = expFv; s.expRp = expRp;
      plan.push_back(s);
   endtask

   // The bench plays the npc adder, driving the expected current PC plus one.
   task automatic applyStimulus(input step_t s);
      rst         = s.rstN;
      stall       = s.stall;
      fetch_ready = s.rdy;
      exc         = s.exc;
      eret        = s.eret;
      jmp         = s.jmp;
      br_taken    = s.br;
      epc_in      = s.epc;
      jmp_target  = s.jt;
      br_target   = s.bt;
      npc_in      = modelPc + 32'd1;
   endtask

   task automatic test_reset();
      step_t e;
      planStep(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, RESET_PC, 0, 0);
      planStep(0, 0, 1, 1, 1, 1, 1, 9, 9, 9, RESET_PC, 0, 0);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, RESET_PC, 1, 0);
      while (plan.size() > 0) begin
         applyStimulus(plan[0]);
         sb.push_back(plan.pop_front());
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({pc_out, fetch_valid, redir_pend} !== {e.expPc, e.expFv, e.expRp}) begin
            errors++;
            $display("[TB] FAIL reset: got pc=%h fv=%b rp=%b, want pc=%h fv=%b rp=%b",
                     pc_out, fetch_valid, redir_pend, e.expPc, e.expFv, e.expRp);
         end
         modelPc = e.expPc;
      end
   endtask

   task automatic test_sequential();
      step_t e;
      for (int i = 1; i <= 5; i++) planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'(i), 1, 0);
      // Not-ready fetch without a redirect must hold everything.
      planStep(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd5, 1, 0);
      while (plan.size() > 0) begin
         applyStimulus(plan[0]);
         sb.push_back(plan.pop_front());
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({pc_out, fetch_valid, redir_pend} !== {e.expPc, e.expFv, e.expRp}) begin
            errors++;
            $display("[TB] FAIL sequential: got pc=%h fv=%b rp=%b, want pc=%h fv=%b rp=%b",
                     pc_out, fetch_valid, redir_pend, e.expPc, e.expFv, e.expRp);
         end
         modelPc = e.expPc;
      end
   endtask

   task automatic test_priority();
      step_t e;
      planStep(1, 0, 1, 0, 0, 0, 1, 0,   0,  20, 32'd20,  1, 0);
      planStep(1, 0, 1, 0, 0, 0, 0, 0,   0,  0,  32'd21,  1, 0);
      planStep(1, 0, 1, 1, 0, 1, 1, 0,   40, 20, EXC_VEC, 1, 0);
      planStep(1, 0, 1, 0, 1, 1, 1, 100, 40, 20, 32'd100, 1, 0);
      planStep(1, 0, 1, 0, 0, 1, 1, 0,   40, 20, 32'd40,  1, 0);
      planStep(1, 0, 1, 0, 0, 0, 0, 0,   0,  0,  32'd41,  1, 0);
      while (plan.size() > 0) begin
         applyStimulus(plan[0]);
         sb.push_back(plan.pop_front());
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({pc_out, fetch_valid, redir_pend} !== {e.expPc, e.expFv, e.expRp}) begin
            errors++;
            $display("[TB] FAIL priority: got pc=%h fv=%b rp=%b, want pc=%h fv=%b rp=%b",
                     pc_out, fetch_valid, redir_pend, e.expPc, e.expFv, e.expRp);
         end
         modelPc = e.expPc;
      end
   endtask

   task automatic test_stall_hold();
      step_t e;
      planStep(1, 1, 1, 0, 0, 1, 0, 0, 40, 0, 32'd41, 1, 1);
      for (int i = 0; i < 3; i++) planStep(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'd41, 1, 1);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'd40, 1, 0);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'd41, 1, 0);
      while (plan.size() > 0) begin
         applyStimulus(plan[0]);
         sb.push_back(plan.pop_front());
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({pc_out, fetch_valid, redir_pend} !== {e.expPc, e.expFv, e.expRp}) begin
            errors++;
            $display("[TB] FAIL stall_hold: got pc=%h fv=%b rp=%b, want pc=%h fv=%b rp=%b",
                     pc_out, fetch_valid, redir_pend, e.expPc, e.expFv, e.expRp);
         end
         modelPc = e.expPc;
      end
   endtask

   task automatic test_pend_replace();
      step_t e;
      // Held br replaced by a later exc.
      planStep(1, 1, 1, 0, 0, 0, 1, 0, 0, 20, 32'd41,  1, 1);
      planStep(1, 1, 1, 1, 0, 0, 0, 0, 0, 0,  32'd41,  1, 1);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  EXC_VEC, 1, 0);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  32'd2,   1, 0);
      // Held exc survives a later br, including a not-ready cycle.
      planStep(1, 1, 1, 1, 0, 0, 0, 0, 0, 0,  32'd2,   1, 1);
      planStep(1, 1, 1, 0, 0, 0, 1, 0, 0, 20, 32'd2,   1, 1);
      planStep(1, 0, 0, 0, 0, 0, 1, 0, 0, 20, 32'd2,   1, 1);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  EXC_VEC, 1, 0);
      // Equal priority: the later jump wins.
      planStep(1, 1, 1, 0, 0, 1, 0, 0, 40, 0, EXC_VEC, 1, 1);
      planStep(1, 1, 1, 0, 0, 1, 0, 0, 50, 0, EXC_VEC, 1, 1);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  32'd50,  1, 0);
      // Release cycle carrying a higher-priority redirect overrides the held one.
      planStep(1, 1, 1, 0, 0, 0, 1, 0, 0, 20, 32'd50,  1, 1);
      planStep(1, 0, 1, 0, 0, 1, 0, 0, 60, 0, 32'd60,  1, 0);
      // Release cycle carrying a lower-priority redirect loses to the held eret.
      planStep(1, 1, 1, 0, 1, 0, 0, 100, 0, 0, 32'd60,  1, 1);
      planStep(1, 0, 1, 0, 0, 0, 1, 0, 0, 20,  32'd100, 1, 0);
      while (plan.size() > 0) begin
         applyStimulus(plan[0]);
         sb.push_back(plan.pop_front());
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({pc_out, fetch_valid, redir_pend} !== {e.expPc, e.expFv, e.expRp}) begin
            errors++;
            $display("[TB] FAIL pend_replace: got pc=%h fv=%b rp=%b, want pc=%h fv=%b rp=%b",
                     pc_out, fetch_valid, redir_pend, e.expPc, e.expFv, e.expRp);
         end
         modelPc = e.expPc;
      end
   endtask

   task automatic test_wrap_and_reset_in_hold();
      step_t e;
      planStep(1, 0, 1, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1, 0);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1, 1, 0);
      planStep(1, 1, 1, 0, 0, 1, 0, 0, 40, 0, 32'h1, 1, 1);
      planStep(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, RESET_PC, 0, 0);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, RESET_PC, 1, 0);
      planStep(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1, 1, 0);
      while (plan.size() > 0) begin
         applyStimulus(plan[0]);
         sb.push_back(plan.pop_front());
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ({pc_out, fetch_valid, redir_pend} !== {e.expPc, e.expFv, e.expRp}) begin
            errors++;
            $display("[TB] FAIL wrap_reset_hold: got pc=%h fv=%b rp=%b, want pc=%h fv=%b rp=%b",
                     pc_out, fetch_valid, redir_pend, e.expPc, e.expFv, e.expRp);
         end
         modelPc = e.expPc;
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      modelPc     = RESET_PC;
      rst         = 1'b0;
      stall       = 1'b0;
      fetch_ready = 1'b0;
      npc_in      = 32'h0;
      br_taken    = 1'b0;
      br_target   = 32'h0;
      jmp         = 1'b0;
      jmp_target  = 32'h0;
      eret        = 1'b0;
      epc_in      = 32'h0;
      exc         = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_sequential();
      test_priority();
      test_stall_hold();
      test_pend_replace();
      test_wrap_and_reset_in_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
